// File: rtl/monobit_pkg.sv
// Shared types and constants for the monobit frequency-test sequencer.
// Holds the FSM state encoding, window-length limits and accumulator width derivation.
package monobit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam int MIN_LOG2_LEN     = 3;
  localparam int DEF_MAX_LOG2_LEN = 12;

  // Signed sum of a 2^L window spans -2^L..+2^L, which needs L+2 bits.
  function automatic int sum_width(input int max_log2_len);
    return max_log2_len + 2;
  endfunction

endpackage

// File: rtl/monobit_acc.sv
// Up/down accumulator of +1/-1 per accepted bit, with a window bit counter
// whose terminal-count flag marks the final bit of a 2^l_eff window.
module monobit_acc
  import monobit_pkg::*;
#(
  parameter int MAX_LOG2_LEN = DEF_MAX_LOG2_LEN,
  parameter int SUM_W        = sum_width(MAX_LOG2_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [3:0]       l_eff,
  output logic [SUM_W-1:0] s,
  output logic             last
);

  logic [MAX_LOG2_LEN:0] count;
  logic [MAX_LOG2_LEN:0] term;

  always_comb begin
    term = ((MAX_LOG2_LEN+1)'(1) << l_eff) - (MAX_LOG2_LEN+1)'(1);
  end

  assign last = (count == term);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s     <= '0;
      count <= '0;
    end else if (en) begin
      s     <= bit_in ? s + SUM_W'(1) : s - SUM_W'(1);
      count <= count + (MAX_LOG2_LEN+1)'(1);
    end
  end

endmodule

// File: rtl/monobit_seq_ctrl.sv
// Monobit test sequencer: frames a handshaked bit stream into 2^L windows and
// reports |S| <= threshold. Define MONOBIT_FAILCNT_EN to add the fail_cnt output.
module monobit_seq_ctrl
  import monobit_pkg::*;
#(
  parameter int MAX_LOG2_LEN = DEF_MAX_LOG2_LEN,
  parameter int SUM_W        = sum_width(MAX_LOG2_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       cfg_log2_len,
  input  logic [SUM_W-2:0] cfg_threshold,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             pass,
  output logic [SUM_W-1:0] sum
`ifdef MONOBIT_FAILCNT_EN
  ,
  output logic [7:0]       fail_cnt
`endif
);

  state_t state, state_nxt;
  logic [3:0]              l_eff;
  logic [SUM_W-2:0]        thr_q;
  logic signed [SUM_W-1:0] acc_s;
  logic                    acc_last;
  logic                    start_win;
  logic                    accept;
  logic                    clr;
  logic                    pass_nxt;

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l < 4'(MIN_LOG2_LEN)) return 4'(MIN_LOG2_LEN);
    if (l > 4'(MAX_LOG2_LEN)) return 4'(MAX_LOG2_LEN);
    return l;
  endfunction

  // |S| never exceeds 2^MAX_LOG2_LEN, so the sign bit can be dropped.
  function automatic logic [SUM_W-2:0] abs_sum(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-1:0] m;
    m = v[SUM_W-1] ? SUM_W'(-v) : SUM_W'(v);
    return m[SUM_W-2:0];
  endfunction

  monobit_acc #(
    .MAX_LOG2_LEN(MAX_LOG2_LEN),
    .SUM_W       (SUM_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (accept),
    .bit_in(bit_in),
    .l_eff (l_eff),
    .s     (acc_s),
    .last  (acc_last)
  );

  always_comb begin
    state_nxt = state;
    bit_ready = 1'b0;
    start_win = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, REPORT: begin
        if (start) begin
          state_nxt = COLLECT;
          start_win = 1'b1;
        end
      end
      COLLECT: begin
        bit_ready = 1'b1;
        accept    = bit_valid;
        if (bit_valid && acc_last) state_nxt = EVAL;
      end
      EVAL:    state_nxt = REPORT;
      default: state_nxt = IDLE;
    endcase
    // abort overrides start and a final-bit acceptance in the same cycle
    if (abort) begin
      state_nxt = IDLE;
      bit_ready = 1'b0;
      start_win = 1'b0;
      accept    = 1'b0;
    end
  end

  assign clr      = abort | start_win;
  assign busy     = (state == COLLECT) | (state == EVAL);
  assign pass_nxt = (abs_sum(acc_s) <= thr_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_eff <= '0;
      thr_q <= '0;
    end else if (start_win) begin
      l_eff <= clamp_len(cfg_log2_len);
      thr_q <= cfg_threshold;
    end
  end

  // Result registers load on the EVAL cycle and are held through REPORT.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      result_valid <= 1'b0;
      pass         <= 1'b0;
      sum          <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_win) result_valid <= 1'b0;
      if (state == EVAL) begin
        pass         <= pass_nxt;
        sum          <= acc_s;
        result_valid <= 1'b1;
        done         <= 1'b1;
      end
    end
  end

`ifdef MONOBIT_FAILCNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= '0;
    end else if (state == EVAL && !abort && !pass_nxt) begin
      fail_cnt <= sat_inc8(fail_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_monobit_seq_ctrl.sv
// Self-checking bench for monobit_seq_ctrl: directed and randomized windows
// checked against a window-level model of the frequency-test rules.
module tb_monobit_seq_ctrl;

  localparam int MAXL = 12;
  localparam int SW   = MAXL + 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, bit_valid, bit_in;
  logic [3:0]    cfg_log2_len;
  logic [SW-2:0] cfg_threshold;
  logic          bit_ready, busy, done, result_valid, pass;
  logic [SW-1:0] sum;
`ifdef MONOBIT_FAILCNT_EN
  logic [7:0]    fail_cnt;
  int            exp_fail = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit win_bits [0:4095];

  always #5 clk = ~clk;

  monobit_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_log2_len (cfg_log2_len),
    .cfg_threshold(cfg_threshold),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .bit_ready    (bit_ready),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .pass         (pass),
    .sum          (sum)
`ifdef MONOBIT_FAILCNT_EN
    ,
    .fail_cnt     (fail_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampl(input int l);
    return (l < 3) ? 3 : ((l > MAXL) ? MAXL : l);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, bit_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_sum"}, sum, 0);
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  // noise: toggle start and cfg inputs while the window is in flight.
  task automatic run_window(input int lcfg, input int thr, input int gap_mode, input bit noise);
    int n, k, ones, s, abs_s, cyc;
    logic vld, exp_pass;
    logic [SW-1:0] es;
    n = 1 << clampl(lcfg);
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(win_bits[i]);
    s = 2 * ones - n;
    abs_s = (s < 0) ? -s : s;
    exp_pass = (abs_s <= thr);
    es = s[SW-1:0];

    cfg_log2_len  = 4'(lcfg);
    cfg_threshold = (SW-1)'(thr);
    bit_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_rv_drop", result_valid, 0);

    k = 0;
    cyc = 0;
    while (k < n) begin
      case (gap_mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 2 == 0);
        default: vld = ($urandom_range(0, 3) != 0);
      endcase
      if (noise) begin
        start         = ($urandom_range(0, 7) == 0);
        cfg_log2_len  = 4'($urandom);
        cfg_threshold = (SW-1)'($urandom);
      end
      bit_valid = vld;
      bit_in    = vld ? win_bits[k] : 1'($urandom);
      chk("collect_ready", bit_ready, 1);
      step();
      if (vld) k++;
      cyc++;
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    start     = noise;
    chk("eval_ready", bit_ready, 0);
    chk("eval_busy", busy, 1);
    chk("eval_done", done, 0);
    step();
    start = 1'b0;
    chk("report_done", done, 1);
    chk("report_rv", result_valid, 1);
    chk("report_busy", busy, 0);
    chk("report_sum", sum, es);
    chk("report_pass", pass, exp_pass);
`ifdef MONOBIT_FAILCNT_EN
    if (!exp_pass && exp_fail < 255) exp_fail++;
    chk("report_failcnt", fail_cnt, exp_fail);
`endif
    step();
    chk("hold_done", done, 0);
    chk("hold_rv", result_valid, 1);
    chk("hold_sum", sum, es);
    chk("hold_pass", pass, exp_pass);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    cfg_log2_len = 4'd3; cfg_threshold = '0;
    step();
    step();
    check_idle("reset");
`ifdef MONOBIT_FAILCNT_EN
    chk("reset_failcnt", fail_cnt, 0);
`endif
    rst = 1'b0;
    step();
    check_idle("post_reset");

    // eight ones back-to-back: S=+8, fails threshold 2
    for (int i = 0; i < 8; i++) win_bits[i] = 1'b1;
    run_window(3, 2, 0, 1'b0);

    // alternating bits with gaps, started from REPORT: S=0, passes threshold 0
    for (int i = 0; i < 8; i++) win_bits[i] = (i % 2 == 0);
    run_window(3, 0, 1, 1'b0);

    // twelve zeros then four ones: S=-8
    for (int i = 0; i < 16; i++) win_bits[i] = (i >= 12);
    run_window(4, 4, 0, 1'b0);
    run_window(4, 8, 2, 1'b0);

    // length clamping at both ends
    for (int i = 0; i < 4096; i++) win_bits[i] = 1'($urandom);
    run_window(1, 16, 2, 1'b0);
    run_window(0, 3, 0, 1'b0);
    run_window(15, 64, 0, 1'b0);

    // abort after 5 of 8 bits, together with start and a valid bit
    cfg_log2_len = 4'd3; cfg_threshold = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
    end
    abort = 1'b1; start = 1'b1; bit_valid = 1'b1;
    step();
    abort = 1'b0; start = 1'b0; bit_valid = 1'b0;
    check_idle("abort");
    step();
    check_idle("abort_stay");
    for (int i = 0; i < 8; i++) win_bits[i] = (i < 3);
    run_window(3, 1, 0, 1'b0);

    // abort while in REPORT clears the held result
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort_report");
`ifdef MONOBIT_FAILCNT_EN
    chk("abort_failcnt", fail_cnt, exp_fail);
`endif

    // randomized windows with gaps and start/cfg noise mid-window
    for (int w = 0; w < 20; w++) begin
      int lc, nb;
      lc = $urandom_range(0, 8);
      nb = 1 << clampl(lc);
      for (int i = 0; i < nb; i++) win_bits[i] = ($urandom_range(0, 9) < 6);
      run_window(lc, $urandom_range(0, nb), 2, 1'b1);
    end

    // reset mid-window
    cfg_log2_len = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom);
      step();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid_reset");
`ifdef MONOBIT_FAILCNT_EN
    exp_fail = 0;
    chk("mid_reset_failcnt", fail_cnt, 0);
`endif
    for (int i = 0; i < 8; i++) win_bits[i] = 1'($urandom);
    run_window(3, 2, 2, 1'b0);

`ifdef MONOBIT_FAILCNT_EN
    // saturation of the fail counter over many failing windows
    for (int i = 0; i < 8; i++) win_bits[i] = 1'b1;
    for (int w = 0; w < 300; w++) run_window(3, 0, 0, 1'b0);
    chk("failcnt_sat", fail_cnt, 255);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("failcnt_abort", fail_cnt, 255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("failcnt_rst", fail_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
